// File: rtl/gray_wptr_gen.sv
// Write-side pointer generator for an asynchronous FIFO.
// Keeps the binary write pointer, publishes a registered Gray copy, derives full/level.
module gray_wptr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    output logic          push_rdy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW:0]   wptr_gray,
    input  logic [AW:0]   rptr_gray_sync,
    output logic          full,
    output logic [AW:0]   level
);

    logic [AW:0] wbin;
    logic [AW:0] wbin_nxt;
    logic [AW:0] gray_nxt;
    logic [AW:0] rbin;
    logic [AW:0] full_cmp;
    logic [AW:0] level_nxt;
    logic        accept;
    logic        full_nxt;

    // Handshake: a push is taken only when a slot is free and not in reset.
    always_comb begin
        accept   = push_vld & ~full & ~rst;
        wr_en    = accept;
        push_rdy = ~full;
        wr_addr  = wbin[AW-1:0];
    end

    // Next pointer and its Gray image; the wrap bit is the pointer MSB.
    always_comb begin
        wbin_nxt = wbin + {{AW{1'b0}}, accept};
        gray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
    end

    // Decode the synchronized remote Gray pointer back to binary.
    always_comb begin
        rbin     = '0;
        rbin[AW] = rptr_gray_sync[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_gray_sync[i];
        end
    end

    // Full when the pointers match with the top two Gray bits inverted.
    always_comb begin
        full_cmp  = {~rptr_gray_sync[AW:AW-1], rptr_gray_sync[AW-2:0]};
        full_nxt  = (gray_nxt == full_cmp);
        level_nxt = wbin_nxt - rbin;
    end

    // Pointer, Gray output, full and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            level     <= '0;
        end else begin
            wbin      <= wbin_nxt;
            wptr_gray <= gray_nxt;
            full      <= full_nxt;
            level     <= level_nxt;
        end
    end

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed bench for gray_wptr_gen with AW=3.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_gray_wptr_gen;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_vld;
    logic          push_rdy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_gray_sync;
    logic          full;
    logic [AW:0]   level;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [AW:0] prev_gray = '0;

    gray_wptr_gen #(.AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_vld       (push_vld),
        .push_rdy       (push_rdy),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wptr_gray      (wptr_gray),
        .rptr_gray_sync (rptr_gray_sync),
        .full           (full),
        .level          (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        push_vld = 1'b0;
        rptr_gray_sync = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Single-bit-change monitor on the published Gray pointer.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("gray_1bit", int'($countones(wptr_gray ^ prev_gray) <= 1), 1);
        end
        prev_gray = wptr_gray;
    end

    logic [3:0] exp_g2 [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    initial begin
        rst = 1'b1;
        push_vld = 1'b0;
        rptr_gray_sync = '0;
        @(negedge clk);

        // 1: reset state
        do_reset(2);
        #1;
        chk("rst_gray", wptr_gray, 0);
        chk("rst_full", full, 0);
        chk("rst_rdy", push_rdy, 1);
        chk("rst_level", level, 0);
        chk("rst_wren", wr_en, 0);
        tick();

        // 2: fill with push_vld held 9 cycles
        for (int k = 0; k < 9; k++) begin
            push_vld = 1'b1;
            #1;
            if (k < 8) begin
                chk("fill_wren", wr_en, 1);
                chk("fill_addr", wr_addr, k);
            end else begin
                chk("blk_wren", wr_en, 0);
                chk("blk_addr", wr_addr, 0);
            end
            tick();
            chk("fill_gray", wptr_gray, exp_g2[(k < 8) ? k : 7]);
            chk("fill_level", level, (k < 8) ? k + 1 : 8);
            chk("fill_full", full, (k >= 7) ? 1 : 0);
        end

        // 3: one pop, then one more push refills
        push_vld = 1'b0;
        rptr_gray_sync = 4'b0001;
        tick();
        chk("pop_full", full, 0);
        chk("pop_level", level, 7);
        chk("pop_rdy", push_rdy, 1);
        push_vld = 1'b1;
        #1;
        chk("re_wren", wr_en, 1);
        chk("re_addr", wr_addr, 0);
        tick();
        push_vld = 1'b0;
        chk("re_gray", wptr_gray, 4'b1101);
        chk("re_level", level, 8);
        chk("re_full", full, 1);

        // 4: streaming with reader one step behind, across the wrap
        do_reset(1);
        tick();
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_vld = 1'b1;
            rptr_gray_sync = gray(4'(i));
            #1;
            chk("str_wren", wr_en, 1);
            chk("str_addr", wr_addr, i % 8);
            tick();
            chk("str_gray", wptr_gray, gray(4'(i + 1)));
            chk("str_level", level, 1);
            chk("str_full", full, 0);
            if (i == 14) chk("wrap_pre", wptr_gray, 4'b1000);
            if (i == 15) chk("wrap_post", wptr_gray, 4'b0000);
        end
        push_vld = 1'b0;
        mon_en = 1'b0;

        // reset with a partial fill and push_vld high takes no push
        do_reset(1);
        push_vld = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstp_wren", wr_en, 0);
        tick();
        chk("rstp_gray", wptr_gray, 0);
        chk("rstp_level", level, 0);
        rst = 1'b0;
        push_vld = 1'b0;

        // 5: reset while full
        do_reset(1);
        push_vld = 1'b1;
        repeat (8) tick();
        chk("f5_full", full, 1);
        rst = 1'b1;
        #1;
        chk("f5_wren", wr_en, 0);
        tick();
        chk("f5_gray", wptr_gray, 0);
        chk("f5_full0", full, 0);
        chk("f5_level", level, 0);
        rst = 1'b0;
        push_vld = 1'b0;

        // 6: five pushes, then remote pointer jumps to binary 2
        do_reset(1);
        push_vld = 1'b1;
        repeat (5) tick();
        push_vld = 1'b0;
        chk("p5_level", level, 5);
        rptr_gray_sync = 4'b0011;
        tick();
        chk("p6_level", level, 3);
        chk("p6_full", full, 0);
        chk("p6_gray", wptr_gray, gray(4'd5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
